// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor:
// ALU op encodings, the default lookahead group size and a configuration
// legality check used at elaboration time.
package pipelined_cla_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int BLOCK_DEFAULT = 8;

  // A configuration is usable when the operand splits into whole lookahead
  // groups and those groups split evenly across the pipeline stages.
  function automatic bit cfg_legal(input int width, input int block, input int stages);
    if (block < 1 || stages < 1 || width < block) return 1'b0;
    if ((width % block) != 0) return 1'b0;
    if (((width / block) % stages) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_cla_group.sv
// One BLOCK-wide carry-lookahead group. Purely combinational: every internal
// carry is a flat two-level sum of products of the bit generates/propagates
// and the group carry-in, and the group generate is the true lookahead
// generate (not a plain OR of the bit generates).
module cla_group #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] s_o,
  output logic             p_o,
  output logic             g_o,
  output logic             cout_o
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;

  // Carry into bit i+1 = g[i] | p[i]g[i-1] | ... | p[i..0]cin, each term
  // built independently so no carry ripples through earlier carries.
  function automatic logic [BLOCK:0] lookahead_carries(input logic [BLOCK-1:0] gi,
                                                       input logic [BLOCK-1:0] pi,
                                                       input logic             ci);
    logic [BLOCK:0] cv;
    logic           gen;
    logic           prop;
    cv[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      gen  = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        gen  = gen | (prop & gi[j]);
        prop = prop & pi[j];
      end
      cv[i+1] = gen | (prop & ci);
    end
    return cv;
  endfunction

  // Group generate/propagate, independent of the carry-in.
  function automatic logic [1:0] group_gp(input logic [BLOCK-1:0] gi,
                                          input logic [BLOCK-1:0] pi);
    logic gen;
    logic prop;
    gen  = 1'b0;
    prop = 1'b1;
    for (int j = BLOCK - 1; j >= 0; j--) begin
      gen  = gen | (prop & gi[j]);
      prop = prop & pi[j];
    end
    return {gen, prop};
  endfunction

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;
  assign c = lookahead_carries(g, p, cin_i);

  assign s_o          = p ^ c[BLOCK-1:0];
  assign {g_o, p_o}   = group_gp(g, p);
  assign cout_o       = g_o | (p_o & cin_i);

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// The operand is cut into NUM_BLK lookahead groups; each of the STAGES
// stages resolves NUM_BLK/STAGES consecutive groups (LSB first) and hands
// its carry-out, the partial sum and the still-unused operand bits to the
// next stage register. Flags are formed in the last stage.
module pipelined_cla_addsub
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = BLOCK_DEFAULT,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NUM_BLK = WIDTH / BLOCK;
  localparam int GPS     = NUM_BLK / STAGES;
  localparam int SW      = GPS * BLOCK;
  localparam int LAST    = STAGES - 1;
  localparam logic [WIDTH-1:0] ONES = '1;

  if (!cfg_legal(WIDTH, BLOCK, STAGES)) begin : g_cfg_illegal
    $fatal(1, "pipelined_cla_addsub: WIDTH must be a multiple of BLOCK and WIDTH/BLOCK a multiple of STAGES");
  end

  // Stage inputs (what each stage register is about to capture)
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];
  logic [STAGES-1:0] st_cin;
  logic [STAGES-1:0] st_vld;
  logic [STAGES-1:0] st_cout;
  logic [WIDTH-1:0]  sum_d  [STAGES];

  // Stage registers
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  a_q    [STAGES];
  logic [WIDTH-1:0]  b_q    [STAGES];
  logic [WIDTH-1:0]  sum_q  [STAGES];
  logic [STAGES-1:0] c_q;
  logic              ovf_q;
  logic              zero_q;

  logic [STAGES-1:0] adv;

  // Group-level nets
  logic [WIDTH-1:0]   grp_sum;
  logic [NUM_BLK-1:0] grp_cin;
  logic [NUM_BLK-1:0] grp_cout;
  logic [NUM_BLK-1:0] grp_p;
  logic [NUM_BLK-1:0] grp_g;
  logic               unused_grp_pg;

  // Group P/G are not needed here: carries between groups of one stage use
  // each group's own lookahead carry-out.
  assign unused_grp_pg = ^{grp_p, grp_g};

  // Stage 0 takes the operands (B inverted, carry-in 1 for subtract);
  // later stages take the skewed state of the stage before them.
  always_comb begin
    st_a[0]   = in_a;
    st_b[0]   = in_b ^ {WIDTH{in_sub == OP_SUB}};
    st_sum[0] = '0;
    st_cin[0] = (in_sub == OP_SUB);
    st_vld[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      st_a[s]   = a_q[s-1];
      st_b[s]   = b_q[s-1];
      st_sum[s] = sum_q[s-1];
      st_cin[s] = c_q[s-1];
      st_vld[s] = vld_q[s-1];
    end
  end

  // A stage may load when it is empty or its content leaves this cycle;
  // the chain runs combinationally back from out_ready so bubbles collapse.
  always_comb begin
    adv       = '0;
    adv[LAST] = !vld_q[LAST] || out_ready;
    for (int s = LAST - 1; s >= 0; s--) begin
      adv[s] = !vld_q[s] || adv[s+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar j = 0; j < NUM_BLK; j++) begin : g_grp
    localparam int S = j / GPS;
    localparam int K = j % GPS;
    if (K == 0) begin : g_first
      assign grp_cin[j] = st_cin[S];
    end else begin : g_chain
      assign grp_cin[j] = grp_cout[j-1];
    end
    cla_group #(.BLOCK(BLOCK)) u_grp (
      .a_i    (st_a[S][j*BLOCK +: BLOCK]),
      .b_i    (st_b[S][j*BLOCK +: BLOCK]),
      .cin_i  (grp_cin[j]),
      .s_o    (grp_sum[j*BLOCK +: BLOCK]),
      .p_o    (grp_p[j]),
      .g_o    (grp_g[j]),
      .cout_o (grp_cout[j])
    );
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - SW)) << (s * SW);
    assign sum_d[s]   = (st_sum[s] & ~MASK) | (grp_sum & MASK);
    assign st_cout[s] = grp_cout[(s + 1) * GPS - 1];

    if (s != LAST) begin : g_mid
      // ---- stage s -> s+1 boundary ----
      // Operands, partial sum and stage carry advance together.
      always_ff @(posedge clock) begin
        if (adv[s]) begin
          a_q[s]   <= st_a[s];
          b_q[s]   <= st_b[s];
          sum_q[s] <= sum_d[s];
          c_q[s]   <= st_cout[s];
        end
      end
    end else begin : g_last
      logic c_msb;
      logic ovf_d;
      logic zero_d;

      // Carry into the MSB is recovered from its sum bit and propagate.
      assign c_msb  = st_a[s][WIDTH-1] ^ st_b[s][WIDTH-1] ^ sum_d[s][WIDTH-1];
      assign ovf_d  = c_msb ^ st_cout[s];
      assign zero_d = ~|sum_d[s];

      // ---- output register boundary ----
      // Result fields are cleared by reset and hold while stalled.
      always_ff @(posedge clock) begin
        if (!reset) begin
          sum_q[s] <= '0;
          c_q[s]   <= 1'b0;
          ovf_q    <= 1'b0;
          zero_q   <= 1'b0;
        end else if (adv[s]) begin
          sum_q[s] <= sum_d[s];
          c_q[s]   <= st_cout[s];
          ovf_q    <= ovf_d;
          zero_q   <= zero_d;
        end
      end
    end
  end

  // Valid bits: cleared by reset, otherwise follow their upstream on load.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) vld_q[s] <= st_vld[s];
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = c_q[LAST];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Successor to the fixed 8-bit lookahead block: operand width and pipeline depth are configurable.
- Adds a subtract mode, carry-out, signed-overflow and zero flags.
- Uses a valid/ready handshake with backpressure and sustains one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK.
- BLOCK, 8, bits per lookahead group.
- STAGES, 4, number of pipeline stages (= latency); must divide WIDTH/BLOCK.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and op present.
- in_ready  output  1  block accepts this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry out; for subtract, 1 = no borrow.
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_sum == 0.

Behaviour:
- Reset: sampled on clock edge while reset == 0.
  - All stage valid bits clear; out_valid = 0; out_sum, out_cout, out_ovf, out_zero = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight results; no partial result ever appears at the output.
- Transfer occurs when valid & ready are both high, on either side.
- Subtract: B operand is inverted and carry-in = 1. Add: carry-in = 0.
- Stage work split: NUM_BLK = WIDTH/BLOCK; each stage resolves NUM_BLK/STAGES consecutive groups, LSB groups first.
- Within a group:
  - p = a^b, g = a&b.
  - Carries use full two-level lookahead from the group carry-in.
  - Group P = AND of p; group G = g[BLOCK-1] | p[BLOCK-1]&g[BLOCK-2] | … (true lookahead generate, not an OR of g).
  - Group carry-out = G | P&cin.
- Carry into stage k+1 is the registered carry-out of stage k.
- Unconsumed operand bits and the partial sum are skewed forward through stage registers.
- Latency: a result appears exactly STAGES cycles after acceptance, provided out_ready has been high.
- Throughput: 1 operation/cycle with out_ready held high.
- Pipeline advance rule:
  - Stage i loads when its downstream slot is empty or draining this cycle.
  - in_ready = !valid[0] | advance[0], combinational from out_ready through the chain.
  - Bubbles collapse: an empty stage accepts even while the output is stalled.
- Stall: with out_ready = 0 and out_valid = 1, all output fields hold stable. The pipe fills to STAGES entries, then in_ready = 0.
- Simultaneous drain and accept when full: allowed, with no bubble inserted.
- Flags are computed in the last stage:
  - out_cout = carry out of MSB.
  - out_ovf = carry into MSB ^ carry out of MSB.
  - out_zero = ~|out_sum.
- Widths: no sign extension; the result wraps modulo 2^WIDTH.
- STAGES = 1 is legal: single-cycle registered output, in_ready = !out_valid | out_ready.

Decomposition:
- Shared constants header: ALU op encodings (OP_ADD = 0, OP_SUB = 1); BLOCK default; a legality check for WIDTH % BLOCK and NUM_BLK % STAGES, failing elaboration on violation.
- One natural sub-module: cla_group. It is purely combinational, BLOCK-wide, and takes a, b, cin and produces s, P, G, cout. It is instantiated NUM_BLK times via generate. Stage registers and handshake logic live in the top module.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with in_valid = 1 -> out_valid = 0 and all outputs 0 throughout; in_ready = 1 the cycle after release.
- Carry ripple across all stages: add A = 0xFFFFFFFF, B = 0x00000001 -> exactly 4 cycles later sum = 0, cout = 1, ovf = 0, zero = 1.
- Subtract overflow: A = 0x80000000 − B = 0x00000001 -> sum = 0x7FFFFFFF, ovf = 1, cout = 1.
- Subtract with borrow: A = 5 − B = 7 -> sum = 0xFFFFFFFE, cout = 0, ovf = 0, zero = 0.
- Backpressure: stream 10 random ops, then hold out_ready = 0 for 6 cycles -> in_ready drops after 4 accepts, outputs stay stable, and release yields all 10 results in order with no loss or duplication (scoreboard vs reference model).
- Mid-flight reset and parametric sweep: assert reset with 3 ops in flight -> no stale outputs afterwards. Rerun the random scoreboard at WIDTH = 16/STAGES = 1, WIDTH = 64/STAGES = 8, and WIDTH = 32/STAGES = 2.
